// File: rtl/vec_mag_pkg.sv
// vec_magnitude_iter shared types and constants.
// State encoding, default component width and counter sizing.
package vec_mag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ITER,
    DONE
  } mag_state_t;

  localparam int DEF_IN_W = 8;

  function automatic int cnt_w(input int out_w);
    return (out_w > 2) ? $clog2(out_w) : 1;
  endfunction

endpackage

// File: rtl/vec_magnitude_iter_step.sv
// mag_sqrt_step: one combinational restoring square-root iteration.
// Produces the next remainder and the root bit for index k.
module mag_sqrt_step #(
  parameter int SUM_W = 17,
  parameter int OUT_W = 9,
  parameter int CNT_W = 4
) (
  input  logic [SUM_W-1:0] rem,
  input  logic [OUT_W-1:0] root,
  input  logic [CNT_W-1:0] k,
  output logic [SUM_W-1:0] rem_next,
  output logic             root_bit
);

  logic [SUM_W-1:0] root_ext;
  logic [SUM_W-1:0] trial;
  int               kk;

  // trial = (2*root + 2^k) * 2^k, bounded below 2^SUM_W
  always_comb begin
    kk       = int'(k);
    root_ext = SUM_W'(root);
    trial    = (root_ext << (kk + 1))
             | (SUM_W'(1) << (2 * kk));
    root_bit = (rem >= trial);
    rem_next = root_bit ? (rem - trial) : rem;
  end

endmodule

// File: rtl/vec_magnitude_iter.sv
// Iterative Euclidean magnitude, one root bit per cycle.
// Define VEC_MAG_ROUND_EN to round to nearest instead of floor.
module vec_magnitude_iter
  import vec_mag_pkg::*;
#(
  parameter int IN_W = DEF_IN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_x,
  input  logic [IN_W-1:0]   in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W:0]     out_mag,
  output logic              busy
);

  localparam int SUM_W = 2 * IN_W + 1;
  localparam int OUT_W = IN_W + 1;
  localparam int CNT_W = cnt_w(OUT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUT_W - 1);

  mag_state_t       state;
  mag_state_t       state_d;
  logic [IN_W-1:0]  x_q;
  logic [IN_W-1:0]  y_q;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] rem;
  logic [OUT_W-1:0] root;
  logic [CNT_W-1:0] cnt;

  logic [SUM_W-1:0] sq;
  logic [SUM_W-1:0] rem_src;
  logic [SUM_W-1:0] rem_nx;
  logic             root_bit;
  logic [OUT_W-1:0] root_nx;
  logic [OUT_W-1:0] mag_fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign sq = SUM_W'(x_q) * SUM_W'(x_q)
            + SUM_W'(y_q) * SUM_W'(y_q);

  // first step works on the fresh sum, later steps on rem
  assign rem_src = (cnt == CNT_MAX) ? sum : rem;

  mag_sqrt_step #(
    .SUM_W (SUM_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_step (
    .rem      (rem_src),
    .root     (root),
    .k        (cnt),
    .rem_next (rem_nx),
    .root_bit (root_bit)
  );

  assign root_nx = root | (OUT_W'(root_bit) << cnt);

`ifdef VEC_MAG_ROUND_EN
  // rem = sum - root^2; rem > root means sqrt is above root + 0.5
  assign mag_fin = (rem_nx > SUM_W'(root_nx))
                 ? root_nx + OUT_W'(1)
                 : root_nx;
`else
  assign mag_fin = root_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   if (in_valid) state_d = SQUARE;
      SQUARE: state_d = ITER;
      ITER:   if (cnt == '0) state_d = DONE;
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      sum     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      out_mag <= '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q <= in_x;
            y_q <= in_y;
          end
        end
        SQUARE: begin
          sum  <= sq;
          rem  <= '0;
          root <= '0;
          cnt  <= CNT_MAX;
        end
        ITER: begin
          rem  <= rem_nx;
          root <= root_nx;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) out_mag <= mag_fin;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/vec_magnitude_iter.md
Name: vec_magnitude_iter

Overview:
- Iterative Euclidean magnitude unit: accepts a vector (x, y) and returns floor(sqrt(x^2 + y^2)), or the rounded value when the option is enabled.
- Parametrised in input width.
- Valid/ready handshakes on both sides, so upstream sample logic and downstream consumers can stall it.
- Restoring digit-by-digit square root, one result bit per cycle. Replaces the single-cycle fully unrolled 8-bit root with a small, timing-friendly datapath for the tile.

Parameters:
- IN_W, 8, unsigned width of each input component x and y (4..16).
- SUM_W, 2*IN_W+1, localparam: width of x^2 + y^2; no overflow possible.
- OUT_W, IN_W+1, localparam: result width. sqrt(2)*(2^IN_W-1)+1 < 2^OUT_W, so rounding never overflows.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable; when low all state and outputs hold
- in_valid  in  1  x/y presented
- in_ready  out  1  block can accept a vector
- in_x  in  IN_W  x component, unsigned
- in_y  in  IN_W  y component, unsigned
- out_valid  out  1  out_mag valid
- out_ready  in  1  consumer accepts out_mag
- out_mag  out  OUT_W  magnitude result
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n low) forces:
  - state = IDLE
  - in_ready = 1, out_valid = 0, out_mag = 0, busy = 0
  - internal sum/rem/root/counter = 0
- Reset mid-operation aborts the computation; no result is emitted.
- en = 0 freezes every register, including the FSM and counter. Handshakes complete only on edges with en = 1.
- FSM states: IDLE, SQUARE, ITER, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready & en: register in_x/in_y and go to SQUARE.
- SQUARE:
  - Registers sum = x*x + y*y at SUM_W bits.
  - Clears rem and root; counter = OUT_W-1; go to ITER.
- ITER: one restoring step per cycle, MSB first, with bit index k = counter.
  - trial = (root << (k+1)) | (1 << 2k), computed on rem width.
  - If rem >= trial: rem -= trial, root[k] = 1.
  - Decrement counter.
  - When k = 0 completes, go to DONE.
- DONE:
  - out_valid = 1; out_mag is stable and held until out_ready.
  - On out_valid & out_ready & en: go to IDLE, clear out_valid.
  - The new input is accepted no earlier than the next cycle (in_ready = 0 during DONE).
- Latency: accept edge E0 -> out_valid visible after edge E(OUT_W+1); 10 edges for IN_W = 8.
- Throughput: one vector per OUT_W+3 cycles when out_ready is held high.
- in_ready is 0 in SQUARE, ITER and DONE. in_valid during those states is ignored; the source must hold data.
- out_mag updates only on the DONE entry edge, never while out_valid = 1.
- Zero input gives out_mag = 0. Maximum input gives floor(sqrt(2)*(2^IN_W-1)).

Optional Feature:
- Macro VEC_MAG_ROUND_EN.
- Defined: on DONE entry, if final rem > root then out_mag = root+1, else root. This rounds to nearest; an exact half cannot occur for integer input. Adds no latency.
- Undefined: out_mag = root (floor); rounding logic is absent.

Decomposition:
- Package vec_mag_pkg holds:
  - state enum type mag_state_t {IDLE, SQUARE, ITER, DONE}
  - default IN_W constant
  - helper function for the counter width, clog2(OUT_W)
- One sub-module: mag_sqrt_step.
  - Combinational single restoring iteration.
  - Inputs: rem, root, k. Outputs: rem_next, root_bit.
  - Instantiated once inside the ITER datapath.

Test Plan:
- x = 3, y = 4, out_ready = 1 -> out_mag = 5, out_valid high for exactly 1 cycle, first high after edge E10 (IN_W = 8).
- x = 255, y = 255 -> out_mag = 360 floor; 361 with VEC_MAG_ROUND_EN (sum 130050, rem 450 > 360).
- x = 0, y = 0 -> 0. Then x = 1, y = 1 -> 1 floor, 1 rounded (rem 1 not > 1).
- Backpressure: out_ready = 0 for 20 cycles after x = 6, y = 8 -> out_valid stays 1, out_mag = 10 stable, in_ready = 0; release -> IDLE next cycle.
- Reset mid-ITER, plus en = 0 for 5 cycles during ITER:
  - rst_n pulse -> all outputs at reset values immediately (async), no result emitted.
  - en low -> state frozen, latency extends by exactly 5 cycles.
- Back-to-back: in_valid held with 4 vectors, out_ready = 1 -> 4 correct results, one every OUT_W+3 = 12 cycles, none dropped or duplicated.
